// File: rtl/evm_ballot_controller.sv
// rtl/evm_ballot_controller.sv - ballot sequencing controller for an electronic voting machine
//
// Purpose:
//   Sequences one poll: the officer opens the poll, then grants ballots one at a
//   time. Each armed ballot accepts exactly one single-button press and emits
//   one vote strobe. A close request that arrives mid-ballot is held until that
//   ballot finishes. After the close, the block stays sealed until reset.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   poll_open    officer pulse, opens the poll (IDLE only)
//   poll_close   officer pulse, closes the poll (deferred while a ballot is in flight)
//   ballot_issue officer pulse, arms one ballot (READY only, buttons must be released)
//   btn          synchronised candidate buttons, one bit per candidate
//   vote_valid   one-cycle vote strobe to the counter datapath
//   vote_id      candidate index, valid with vote_valid
//   ballot_ready voter lamp, high while a ballot is armed
//   poll_active  high from poll open until poll close
//   poll_closed  high once the poll is sealed
//   multi_press  one-cycle pulse when a multi-button press is rejected
//   timeout      one-cycle pulse when an armed ballot expires
//   total_votes  saturating count of votes cast
//
// Build option:
//   EVM_TIMEOUT_EN  when defined, an armed ballot expires after TIMEOUT_CYCLES
//                   cycles without an accepted press; otherwise timeout is tied
//                   low and no counter exists.

module evm_ballot_controller #(
  parameter int NUM_CAND       = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                poll_open,
  input  logic                poll_close,
  input  logic                ballot_issue,
  input  logic [NUM_CAND-1:0] btn,
  output logic                vote_valid,
  output logic [3:0]          vote_id,
  output logic                ballot_ready,
  output logic                poll_active,
  output logic                poll_closed,
  output logic                multi_press,
  output logic                timeout,
  output logic [15:0]         total_votes
);

  // vote_id is 4 bits wide, and the expiry cycle is flagged one cycle early.
  // Together these fix the legal parameter ranges.
  if (NUM_CAND < 2 || NUM_CAND > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("evm_ballot_controller: NUM_CAND must be 2..16 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_ARMED,
    S_CAST,
    S_RELEASE,
    S_CLOSED
  } state_t;

  localparam logic [NUM_CAND-1:0] BTN_ONE = {{(NUM_CAND-1){1'b0}}, 1'b1};

  state_t      state_q, state_d;
  logic        close_pend_q, close_pend_d;
  logic [3:0]  vote_id_q, vote_id_d;
  logic        vote_valid_q, vote_valid_d;
  logic        multi_press_q, multi_press_d;
  logic        multi_prev_q, multi_prev_d;
  logic        ballot_ready_q, ballot_ready_d;
  logic        poll_active_q, poll_active_d;
  logic        poll_closed_q, poll_closed_d;
  logic [15:0] total_votes_q, total_votes_d;

  logic        btn_none;
  logic        btn_multi;
  logic        btn_one;
  logic [3:0]  btn_idx;
  logic        armed_expired;

  // Button decode: x & (x-1) clears the lowest set bit. If the result is
  // non-zero, two or more buttons are down.
  assign btn_none  = (btn == '0);
  assign btn_multi = ((btn & (btn - BTN_ONE)) != '0);
  assign btn_one   = !btn_none && !btn_multi;

  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (btn[i]) begin
        btn_idx = 4'(i);
      end
    end
  end

`ifdef EVM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;

  // tmo_cnt holds (armed cycle number - 1). timeout is raised for the final
  // armed cycle. During that cycle the ballot is abandoned, whatever the buttons.
  always_comb begin
    tmo_cnt_d = '0;
    timeout_d = 1'b0;
    if (state_q == S_ARMED && !timeout_q && !btn_one) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 2)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign armed_expired = timeout_q;
  assign timeout       = timeout_q;
`else
  assign armed_expired = 1'b0;
  assign timeout       = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    close_pend_d  = close_pend_q;
    vote_id_d     = vote_id_q;
    vote_valid_d  = 1'b0;
    multi_press_d = 1'b0;
    multi_prev_d  = 1'b0;
    total_votes_d = total_votes_q;

    case (state_q)
      S_IDLE: begin
        if (poll_open) begin
          state_d = S_READY;
        end
      end

      S_READY: begin
        // Close wins over a simultaneous issue. A button still held from the
        // previous voter blocks arming, so it cannot become the next vote.
        if (poll_close) begin
          state_d = S_CLOSED;
        end else if (ballot_issue && btn_none) begin
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        if (poll_close) begin
          close_pend_d = 1'b1;
        end
        if (armed_expired) begin
          state_d = (close_pend_q || poll_close) ? S_CLOSED : S_READY;
        end else if (btn_one) begin
          state_d      = S_CAST;
          vote_id_d    = btn_idx;
          vote_valid_d = 1'b1;
        end else if (btn_multi) begin
          // One pulse per multi-press episode, not one per cycle held.
          multi_prev_d  = 1'b1;
          multi_press_d = !multi_prev_q;
        end
      end

      S_CAST: begin
        if (poll_close) begin
          close_pend_d = 1'b1;
        end
        if (total_votes_q != 16'hFFFF) begin
          total_votes_d = total_votes_q + 16'd1;
        end
        state_d = S_RELEASE;
      end

      S_RELEASE: begin
        if (poll_close) begin
          close_pend_d = 1'b1;
        end
        if (btn_none) begin
          state_d = (close_pend_q || poll_close) ? S_CLOSED : S_READY;
        end
      end

      S_CLOSED: begin
        state_d = S_CLOSED;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_CLOSED || state_d == S_READY) begin
      close_pend_d = 1'b0;
    end

    // Status outputs are registered from the next state, so they line up with state_q.
    ballot_ready_d = (state_d == S_ARMED);
    poll_active_d  = (state_d == S_READY) || (state_d == S_ARMED) ||
                     (state_d == S_CAST)  || (state_d == S_RELEASE);
    poll_closed_d  = (state_d == S_CLOSED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      close_pend_q   <= 1'b0;
      vote_id_q      <= '0;
      vote_valid_q   <= 1'b0;
      multi_press_q  <= 1'b0;
      multi_prev_q   <= 1'b0;
      ballot_ready_q <= 1'b0;
      poll_active_q  <= 1'b0;
      poll_closed_q  <= 1'b0;
      total_votes_q  <= '0;
    end else begin
      state_q        <= state_d;
      close_pend_q   <= close_pend_d;
      vote_id_q      <= vote_id_d;
      vote_valid_q   <= vote_valid_d;
      multi_press_q  <= multi_press_d;
      multi_prev_q   <= multi_prev_d;
      ballot_ready_q <= ballot_ready_d;
      poll_active_q  <= poll_active_d;
      poll_closed_q  <= poll_closed_d;
      total_votes_q  <= total_votes_d;
    end
  end

  assign vote_valid   = vote_valid_q;
  assign vote_id      = vote_id_q;
  assign ballot_ready = ballot_ready_q;
  assign poll_active  = poll_active_q;
  assign poll_closed  = poll_closed_q;
  assign multi_press  = multi_press_q;
  assign total_votes  = total_votes_q;

endmodule

// File: tb/tb_evm_ballot_controller.sv
// tb/tb_evm_ballot_controller.sv - self-checking bench for evm_ballot_controller

module tb_evm_ballot_controller;

  localparam int NC = 10;
  localparam int TC = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          poll_open;
  logic          poll_close;
  logic          ballot_issue;
  logic [NC-1:0] btn;
  logic          vote_valid;
  logic [3:0]    vote_id;
  logic          ballot_ready;
  logic          poll_active;
  logic          poll_closed;
  logic          multi_press;
  logic          timeout;
  logic [15:0]   total_votes;

  int checks = 0;
  int errors = 0;
  int vv_cnt = 0;
  int mp_cnt = 0;
  int to_cnt = 0;
  logic [3:0] exp_q[$];

  // {vote_valid, ballot_ready, poll_active, poll_closed, multi_press, timeout}
  logic [5:0] outs;
  assign outs = {vote_valid, ballot_ready, poll_active, poll_closed, multi_press, timeout};

  evm_ballot_controller #(
    .NUM_CAND       (NC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .poll_open    (poll_open),
    .poll_close   (poll_close),
    .ballot_issue (ballot_issue),
    .btn          (btn),
    .vote_valid   (vote_valid),
    .vote_id      (vote_id),
    .ballot_ready (ballot_ready),
    .poll_active  (poll_active),
    .poll_closed  (poll_closed),
    .multi_press  (multi_press),
    .timeout      (timeout),
    .total_votes  (total_votes)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every vote strobe must match the oldest expected candidate.
  always @(negedge clk) begin
    if (!reset) begin
      if (vote_valid) begin
        vv_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("vote_expected", exp_q.size(), 1);
        end else begin
          check_eq("vote_id", {28'd0, vote_id}, {28'd0, exp_q.pop_front()});
        end
      end
      if (multi_press) mp_cnt++;
      if (timeout) to_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue();
    ballot_issue = 1'b1;
    step(1);
    ballot_issue = 1'b0;
  endtask

  task automatic cast_vote(input logic [NC-1:0] b, input logic [3:0] id);
    exp_q.push_back(id);
    btn = b;
    step(1);
    check_eq("vote_valid_hi", vote_valid, 1);
    btn = '0;
    step(1);
    check_eq("vote_valid_lo", vote_valid, 0);
    step(1);
  endtask

  initial begin
    reset        = 1'b1;
    poll_open    = 1'b0;
    poll_close   = 1'b0;
    ballot_issue = 1'b0;
    btn          = '0;
    step(3);
    check_eq("reset_outs", outs, 6'b000000);
    check_eq("reset_total", total_votes, 0);
    check_eq("reset_vote_id", vote_id, 0);
    reset = 1'b0;
    step(1);

    // IDLE ignores issue and close
    ballot_issue = 1'b1;
    poll_close   = 1'b1;
    step(1);
    ballot_issue = 1'b0;
    poll_close   = 1'b0;
    check_eq("idle_ignore", outs, 6'b000000);

    poll_open = 1'b1;
    step(1);
    poll_open = 1'b0;
    check_eq("ready_outs", outs, 6'b001000);

    // Basic vote, candidate 3
    issue();
    check_eq("armed_outs", outs, 6'b011000);
    cast_vote(10'h008, 4'd3);
    check_eq("total_after_v1", total_votes, 1);
    check_eq("ready_after_v1", outs, 6'b001000);

    // Multi-press rejected, then highest candidate
    issue();
    btn = 10'h021;
    step(1);
    check_eq("multi_outs", outs, 6'b011010);
    btn = '0;
    step(1);
    check_eq("multi_one_cycle", outs, 6'b011000);
    cast_vote(10'h200, 4'd9);
    check_eq("total_after_v2", total_votes, 2);
    check_eq("mp_cnt", mp_cnt, 1);

    // Held button blocks arming
    btn = 10'h002;
    issue();
    check_eq("held_no_arm", outs, 6'b001000);
    step(3);
    btn = '0;
    step(2);
    check_eq("held_no_arm_after", outs, 6'b001000);

    // Long hold after a vote with a second issue in the middle
    issue();
    exp_q.push_back(4'd4);
    btn = 10'h010;
    step(1);
    check_eq("hold_vote_hi", vote_valid, 1);
    for (int i = 0; i < 20; i++) begin
      ballot_issue = (i == 10);
      step(1);
    end
    ballot_issue = 1'b0;
    check_eq("hold_release_outs", outs, 6'b001000);
    btn = '0;
    step(3);
    check_eq("hold_vv_cnt", vv_cnt, 3);
    check_eq("hold_total", total_votes, 3);
    check_eq("hold_no_rearm", outs, 6'b001000);

`ifdef EVM_TIMEOUT_EN
    issue();
    step(6);
    check_eq("tmo_cycle7", outs, 6'b011000);
    step(1);
    check_eq("tmo_cycle8", outs, 6'b011001);
    step(1);
    check_eq("tmo_ready", outs, 6'b001000);
    check_eq("tmo_total", total_votes, 3);
    check_eq("tmo_cnt", to_cnt, 1);
    issue();
`else
    issue();
    step(40);
    check_eq("no_tmo_armed", outs, 6'b011000);
    check_eq("no_tmo_cnt", to_cnt, 0);
`endif

    // Close while armed: ballot completes, then the poll seals
    poll_close = 1'b1;
    step(1);
    poll_close = 1'b0;
    check_eq("close_pending_outs", outs, 6'b011000);
    cast_vote(10'h001, 4'd0);
    check_eq("closed_outs", outs, 6'b000100);
    check_eq("closed_total", total_votes, 4);
    poll_open    = 1'b1;
    ballot_issue = 1'b1;
    step(1);
    poll_open    = 1'b0;
    ballot_issue = 1'b0;
    btn = 10'h004;
    step(3);
    btn = '0;
    step(1);
    check_eq("closed_terminal", outs, 6'b000100);
    check_eq("closed_total2", total_votes, 4);
    check_eq("closed_vv_cnt", vv_cnt, 4);

    // Reset mid-ballot discards the ballot
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    poll_open = 1'b1;
    step(1);
    poll_open = 1'b0;
    issue();
    check_eq("rst_armed", outs, 6'b011000);
    reset = 1'b1;
    btn   = 10'h004;
    step(1);
    check_eq("rst_outs", outs, 6'b000000);
    check_eq("rst_total", total_votes, 0);
    check_eq("rst_vote_id", vote_id, 0);
    reset = 1'b0;
    btn   = '0;
    step(2);
    check_eq("rst_idle", outs, 6'b000000);
    check_eq("rst_vv_cnt", vv_cnt, 4);

    // Close and issue together in READY: close wins
    poll_open = 1'b1;
    step(1);
    poll_open    = 1'b0;
    poll_close   = 1'b1;
    ballot_issue = 1'b1;
    step(1);
    poll_close   = 1'b0;
    ballot_issue = 1'b0;
    check_eq("close_wins", outs, 6'b000100);
    check_eq("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
